// File: rtl/cw_output.sv
// Clockwise ring output port: one single-entry buffer per VC, cw/pe round-robin per VC, phase-interleaved send.
// Request edge -> grant next cycle -> cwso the cycle after; cwro=0 parks the flit in its buffer and retries each matching phase.
module cw_output #(
  parameter int DATA_WIDTH = 64,
  parameter int HOP_MSB    = 55,
  parameter int HOP_LSB    = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  req_cw_even,
  input  logic                  req_cw_odd,
  input  logic                  req_pe_even,
  input  logic                  req_pe_odd,
  input  logic [DATA_WIDTH-1:0] data_cw_even,
  input  logic [DATA_WIDTH-1:0] data_cw_odd,
  input  logic [DATA_WIDTH-1:0] data_pe_even,
  input  logic [DATA_WIDTH-1:0] data_pe_odd,
  output logic                  grant_cw_even,
  output logic                  grant_cw_odd,
  output logic                  grant_pe_even,
  output logic                  grant_pe_odd,
  input  logic                  cwro,
  output logic                  cwso,
  output logic [DATA_WIDTH-1:0] cwdo
);

  localparam int HOP_W = HOP_MSB - HOP_LSB + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t            r_st_even;
  buf_state_t            r_st_odd;
  logic [DATA_WIDTH-1:0] r_buf_even;
  logic [DATA_WIDTH-1:0] r_buf_odd;
  // Round-robin pointer: 0 favours cw, 1 favours pe.
  logic                  r_ptr_even;
  logic                  r_ptr_odd;

  logic                  w_arb_even;
  logic                  w_arb_odd;
  logic                  w_win_cw_even;
  logic                  w_win_cw_odd;
  logic                  w_tx_even;
  logic                  w_tx_odd;
  logic [DATA_WIDTH-1:0] w_tx_buf;
  logic [HOP_W-1:0]      w_hop;
  logic [DATA_WIDTH-1:0] w_tx_dat;

  // Even VC accepts on polarity=0 and sends on polarity=1; odd VC is the mirror image.
  assign w_arb_even    = !polarity && (r_st_even == EMPTY) && (req_cw_even || req_pe_even);
  assign w_arb_odd     =  polarity && (r_st_odd  == EMPTY) && (req_cw_odd  || req_pe_odd);
  assign w_win_cw_even = req_cw_even && (!req_pe_even || !r_ptr_even);
  assign w_win_cw_odd  = req_cw_odd  && (!req_pe_odd  || !r_ptr_odd);

  assign w_tx_even = polarity  && (r_st_even == FULL) && cwro;
  assign w_tx_odd  = !polarity && (r_st_odd  == FULL) && cwro;
  assign w_tx_buf  = w_tx_even ? r_buf_even : r_buf_odd;
  assign w_hop     = w_tx_buf[HOP_MSB:HOP_LSB];

  always_comb begin
    w_tx_dat                  = w_tx_buf;
    w_tx_dat[HOP_MSB:HOP_LSB] = w_hop >> 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_even     <= EMPTY;
      r_st_odd      <= EMPTY;
      r_buf_even    <= '0;
      r_buf_odd     <= '0;
      r_ptr_even    <= 1'b0;
      r_ptr_odd     <= 1'b0;
      grant_cw_even <= 1'b0;
      grant_pe_even <= 1'b0;
      grant_cw_odd  <= 1'b0;
      grant_pe_odd  <= 1'b0;
      cwso          <= 1'b0;
      cwdo          <= '0;
    end else begin
      grant_cw_even <= w_arb_even &&  w_win_cw_even;
      grant_pe_even <= w_arb_even && !w_win_cw_even;
      grant_cw_odd  <= w_arb_odd  &&  w_win_cw_odd;
      grant_pe_odd  <= w_arb_odd  && !w_win_cw_odd;

      case (r_st_even)
        EMPTY: begin
          if (w_arb_even) begin
            r_buf_even <= w_win_cw_even ? data_cw_even : data_pe_even;
            r_ptr_even <= w_win_cw_even;
            r_st_even  <= FULL;
          end
        end
        FULL: begin
          if (w_tx_even) begin
            r_st_even <= EMPTY;
          end
        end
        default: r_st_even <= EMPTY;
      endcase

      case (r_st_odd)
        EMPTY: begin
          if (w_arb_odd) begin
            r_buf_odd <= w_win_cw_odd ? data_cw_odd : data_pe_odd;
            r_ptr_odd <= w_win_cw_odd;
            r_st_odd  <= FULL;
          end
        end
        FULL: begin
          if (w_tx_odd) begin
            r_st_odd <= EMPTY;
          end
        end
        default: r_st_odd <= EMPTY;
      endcase

      cwso <= w_tx_even || w_tx_odd;
      if (w_tx_even || w_tx_odd) begin
        cwdo <= w_tx_dat;
      end
    end
  end

endmodule

// File: tb/tb_cw_output.sv
// Directed bench for cw_output: arbitration, phase gating, hop decrement, backpressure and reset.
module tb_cw_output;

  logic        clk;
  logic        rst;
  logic        polarity;
  logic        req_cw_even, req_cw_odd, req_pe_even, req_pe_odd;
  logic [63:0] data_cw_even, data_cw_odd, data_pe_even, data_pe_odd;
  logic        grant_cw_even, grant_cw_odd, grant_pe_even, grant_pe_odd;
  logic        cwro;
  logic        cwso;
  logic [63:0] cwdo;

  int n_cmp = 0;
  int n_bad = 0;

  cw_output #(.DATA_WIDTH(64), .HOP_MSB(55), .HOP_LSB(48)) dut (
    .clk          (clk),
    .rst          (rst),
    .polarity     (polarity),
    .req_cw_even  (req_cw_even),
    .req_cw_odd   (req_cw_odd),
    .req_pe_even  (req_pe_even),
    .req_pe_odd   (req_pe_odd),
    .data_cw_even (data_cw_even),
    .data_cw_odd  (data_cw_odd),
    .data_pe_even (data_pe_even),
    .data_pe_odd  (data_pe_odd),
    .grant_cw_even(grant_cw_even),
    .grant_cw_odd (grant_cw_odd),
    .grant_pe_even(grant_pe_even),
    .grant_pe_odd (grant_pe_odd),
    .cwro         (cwro),
    .cwso         (cwso),
    .cwdo         (cwdo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: outputs are settled #1 after the edge, and polarity flips to the next edge's phase.
  task automatic cyc();
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  task automatic clear_inputs();
    req_cw_even = 0; req_cw_odd = 0; req_pe_even = 0; req_pe_odd = 0;
    data_cw_even = '0; data_cw_odd = '0; data_pe_even = '0; data_pe_odd = '0;
    cwro = 0;
  endtask

  // Reset and leave polarity=0 for the next edge.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    if (polarity) cyc();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    cyc();
    cyc();
    if ({grant_cw_even, grant_pe_even, grant_cw_odd, grant_pe_odd} !== 4'b0000) begin
      $display("FAIL reset_grants got=%b want=0000", {grant_cw_even, grant_pe_even, grant_cw_odd, grant_pe_odd});
      n_bad++;
    end
    n_cmp++;
    if (cwso !== 1'b0) begin
      $display("FAIL reset_cwso got=%b want=0", cwso);
      n_bad++;
    end
    n_cmp++;
    if (cwdo !== 64'h0) begin
      $display("FAIL reset_cwdo got=%h want=0", cwdo);
      n_bad++;
    end
    n_cmp++;
    rst = 0;
    cwro = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (cwso !== 1'b0) begin
        $display("FAIL reset_idle_cwso cyc=%0d got=%b want=0", i, cwso);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_single();
    do_reset();
    cwro = 1;
    req_cw_even = 1;
    data_cw_even = 64'h0004_0000_0000_00AA;
    cyc();
    req_cw_even = 0;
    if ({grant_cw_even, grant_pe_even, cwso} !== 3'b100) begin
      $display("FAIL single_grant got g_cw,g_pe,so=%b want=100", {grant_cw_even, grant_pe_even, cwso});
      n_bad++;
    end
    n_cmp++;
    cyc();
    if ({grant_cw_even, cwso} !== 2'b01) begin
      $display("FAIL single_send got g_cw,so=%b want=01", {grant_cw_even, cwso});
      n_bad++;
    end
    n_cmp++;
    if (cwdo !== 64'h0002_0000_0000_00AA) begin
      $display("FAIL single_cwdo got=%h want=0002_0000_0000_00aa", cwdo);
      n_bad++;
    end
    n_cmp++;
    cyc();
    if (cwso !== 1'b0 || cwdo !== 64'h0002_0000_0000_00AA) begin
      $display("FAIL single_hold got so=%b do=%h want so=0 do=0002_0000_0000_00aa", cwso, cwdo);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_contention();
    logic        exp_gcw [6] = '{1, 0, 0, 0, 1, 0};
    logic        exp_gpe [6] = '{0, 0, 1, 0, 0, 0};
    logic        exp_so  [6] = '{0, 1, 0, 1, 0, 1};
    logic [63:0] exp_do  [6] = '{64'h0, 64'h1111_3344_5566_7788, 64'h1111_3344_5566_7788,
                                 64'hFF7F_0000_0000_0001, 64'hFF7F_0000_0000_0001,
                                 64'h1111_3344_5566_7788};
    do_reset();
    cyc();
    cwro = 1;
    req_cw_odd = 1;
    req_pe_odd = 1;
    data_cw_odd = 64'h1122_3344_5566_7788;
    data_pe_odd = 64'hFFFF_0000_0000_0001;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (grant_cw_odd !== exp_gcw[i] || grant_pe_odd !== exp_gpe[i]) begin
        $display("FAIL contention_grant cyc=%0d got cw=%b pe=%b want cw=%b pe=%b",
                 i, grant_cw_odd, grant_pe_odd, exp_gcw[i], exp_gpe[i]);
        n_bad++;
      end
      n_cmp++;
      if (cwso !== exp_so[i] || (exp_so[i] && cwdo !== exp_do[i])) begin
        $display("FAIL contention_send cyc=%0d got so=%b do=%h want so=%b do=%h",
                 i, cwso, cwdo, exp_so[i], exp_do[i]);
        n_bad++;
      end
      n_cmp++;
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_cw_even = 1;
    data_cw_even = 64'h00AA_0000_0000_0055;
    cyc();
    if (grant_cw_even !== 1'b1) begin
      $display("FAIL bp_first_grant got=%b want=1", grant_cw_even);
      n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if ({cwso, grant_cw_even, grant_pe_even} !== 3'b000) begin
        $display("FAIL bp_stall cyc=%0d got so,g_cw,g_pe=%b want=000", i, {cwso, grant_cw_even, grant_pe_even});
        n_bad++;
      end
      n_cmp++;
    end
    cwro = 1;
    cyc();
    if (cwso !== 1'b1 || cwdo !== 64'h0055_0000_0000_0055) begin
      $display("FAIL bp_release got so=%b do=%h want so=1 do=0055_0000_0000_0055", cwso, cwdo);
      n_bad++;
    end
    n_cmp++;
    cyc();
    req_cw_even = 0;
    if (cwso !== 1'b0 || grant_cw_even !== 1'b1) begin
      $display("FAIL bp_after got so=%b g_cw=%b want so=0 g_cw=1", cwso, grant_cw_even);
      n_bad++;
    end
    n_cmp++;
    cyc();
    if (cwso !== 1'b1) begin
      $display("FAIL bp_second_send got=%b want=1", cwso);
      n_bad++;
    end
    n_cmp++;
    clear_inputs();
  endtask

  task automatic test_both_vcs();
    do_reset();
    cwro = 1;
    req_cw_even = 1;
    req_cw_odd = 1;
    data_cw_even = 64'h0010_0000_0000_EEEE;
    data_cw_odd  = 64'h0020_0000_0000_0D0D;
    cyc();
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (cwso !== 1'b1 || cwdo !== ((i % 2 == 0) ? 64'h0008_0000_0000_EEEE : 64'h0010_0000_0000_0D0D)) begin
        $display("FAIL both_vcs cyc=%0d got so=%b do=%h want so=1 do=%h", i, cwso, cwdo,
                 (i % 2 == 0) ? 64'h0008_0000_0000_EEEE : 64'h0010_0000_0000_0D0D);
        n_bad++;
      end
      n_cmp++;
    end
    clear_inputs();
  endtask

  task automatic test_hop_zero_and_phase();
    do_reset();
    cwro = 1;
    // Odd request offered on an even edge must wait for the odd phase.
    req_pe_odd = 1;
    data_pe_odd = 64'hAB00_CDEF_0123_4567;
    cyc();
    if (grant_pe_odd !== 1'b0) begin
      $display("FAIL phase_ignore got=%b want=0", grant_pe_odd);
      n_bad++;
    end
    n_cmp++;
    cyc();
    req_pe_odd = 0;
    if (grant_pe_odd !== 1'b1 || grant_cw_odd !== 1'b0) begin
      $display("FAIL phase_grant got pe=%b cw=%b want pe=1 cw=0", grant_pe_odd, grant_cw_odd);
      n_bad++;
    end
    n_cmp++;
    cyc();
    if (cwso !== 1'b1 || cwdo !== 64'hAB00_CDEF_0123_4567) begin
      $display("FAIL hop_zero got so=%b do=%h want so=1 do=ab00_cdef_0123_4567", cwso, cwdo);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    cwro = 1;
    req_cw_even = 1;
    data_cw_even = 64'h0040_0000_0000_1234;
    cyc();
    req_cw_even = 0;
    cyc();
    if (cwdo !== 64'h0020_0000_0000_1234) begin
      $display("FAIL midop_pre got=%h want=0020_0000_0000_1234", cwdo);
      n_bad++;
    end
    n_cmp++;
    cwro = 0;
    req_cw_even = 1;
    req_cw_odd = 1;
    data_cw_even = 64'h0080_0000_0000_BEEF;
    data_cw_odd  = 64'h0060_0000_0000_CAFE;
    cyc();
    cyc();
    req_cw_even = 0;
    req_cw_odd = 0;
    rst = 1;
    cyc();
    rst = 0;
    if ({grant_cw_even, grant_pe_even, grant_cw_odd, grant_pe_odd, cwso} !== 5'b00000 || cwdo !== 64'h0) begin
      $display("FAIL midop_reset got grants,so=%b do=%h want 00000 do=0",
               {grant_cw_even, grant_pe_even, grant_cw_odd, grant_pe_odd, cwso}, cwdo);
      n_bad++;
    end
    n_cmp++;
    cwro = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (cwso !== 1'b0) begin
        $display("FAIL midop_stale cyc=%0d got so=%b do=%h want so=0", i, cwso, cwdo);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  initial begin
    polarity = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_both_vcs();
    test_hop_zero_and_phase();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cw_output.md
CW_OUTPUT -- requirements
Module: cw_output

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, flit width.
REQ-002 SHALL have parameter HOP_MSB, default 55, and HOP_LSB, default 48, hop-field bit range.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port polarity, input, 1, router phase; toggles every cycle.
REQ-006 SHALL have ports req_cw_even, req_cw_odd, input, 1 each, requests from the cw input port.
REQ-007 SHALL have ports req_pe_even, req_pe_odd, input, 1 each, requests from the PE input port.
REQ-008 SHALL have ports data_cw_even, data_cw_odd, data_pe_even, data_pe_odd, input, DATA_WIDTH each, flits accompanying the requests.
REQ-009 SHALL have ports grant_cw_even, grant_cw_odd, grant_pe_even, grant_pe_odd, output, 1 each, registered grants.
REQ-010 SHALL have port cwro, input, 1, downstream ready.
REQ-011 SHALL have port cwso, output, 1, send strobe to downstream.
REQ-012 SHALL have port cwdo, output, DATA_WIDTH, flit to downstream.

Function
REQ-013 SHALL hold one single-entry buffer per VC (even, odd), each with a 2-state FSM: EMPTY, FULL.
REQ-014 SHALL arbitrate the even VC only on edges where polarity=0, and the odd VC only where polarity=1.
REQ-015 SHALL arbitrate a VC only while its buffer is EMPTY; a FULL buffer blocks all grants for that VC.
REQ-016 SHALL use per-VC round-robin between cw and pe requesters; the pointer flips to the non-winner after each grant; reset pointer favours cw.
REQ-017 SHALL, on an arbitration edge, capture the winner's data into the buffer, move EMPTY->FULL, and assert the winner's grant for exactly the following cycle.
REQ-018 SHALL never assert more than one grant per VC in a cycle; grants are never asserted in consecutive cycles for the same VC.
REQ-019 SHALL transmit the even buffer only on edges where polarity=1, and the odd buffer only where polarity=0, when the buffer is FULL and cwro=1.
REQ-020 SHALL, on a transmit edge, register cwso=1 for one cycle, load cwdo, and move the buffer FULL->EMPTY.
REQ-021 SHALL form cwdo from the buffer with the hop field [HOP_MSB:HOP_LSB] logically shifted right by 1 and all other bits unchanged.
REQ-022 SHALL hold cwdo at its last value and drive cwso=0 on all non-transmit cycles.
REQ-023 SHALL hold a FULL buffer indefinitely while cwro=0 and retry on each matching-phase edge.
REQ-024 SHALL have latency: request sampled at edge E -> grant high in cycle E+1 -> cwso high in cycle E+2 when cwro=1.
REQ-025 SHALL, because accept and transmit of one VC occur on opposite phases, never accept and transmit the same VC on one edge; the other VC may be accepted on the same edge.
REQ-026 SHALL ignore requests whose parity does not match the current phase; they remain pending.

Reset
REQ-027 SHALL, while rst=1 at an edge: both buffers EMPTY, all grants 0, cwso=0, cwdo=0, both pointers favour cw.
REQ-028 SHALL discard buffered flits on reset mid-operation; no send after reset deasserts until a new grant.

Verification
REQ-029 Single: req_cw_even=1, data 0x0004_0000_0000_00AA, polarity=0 -> grant_cw_even=1 next cycle; cwso=1, cwdo=0x0002_0000_0000_00AA the cycle after.
REQ-030 Contention: req_cw_odd and req_pe_odd held together, cwro=1 -> grants alternate cw, pe, cw; cwso per flit; no double grants.
REQ-031 Backpressure: even buffer FULL, cwro=0 for 6 cycles -> cwso=0, no even grants; cwro=1 -> one cwso on next polarity=1 edge.
REQ-032 Both VCs: continuous even and odd requests, cwro=1 -> cwso every cycle, alternating even/odd data.
REQ-033 Hop zero: hop field 0x00 -> cwdo hop field 0x00, other bits intact.
REQ-034 Reset mid-op: rst while both buffers FULL -> grants 0, cwso 0, cwdo 0; no stale flit sent afterwards.
